// File: rtl/fma_program_sequencer.sv
// fma_program_sequencer
//
// Fetches 32-bit instructions from a program BRAM (2-cycle read latency) and
// runs them one every three cycles. Control and register ops (NOP, END, XOR,
// ADDI, BGE, JUMP) execute locally on a 16 x WORD_WIDTH register file.
// Memory-class ops (SMA, LOADI, SENDL, LOADB, LOAD, WRITEB) are forwarded to
// the FMA data-memory block as one-cycle pulses on instr_out/instr_valid_out,
// along with the register values named by their a/b/c fields.
//
// Build option: define FMA_SEQ_LOADB_HANDSHAKE_EN to hold LOADB in EXEC until
// fma_result_valid_in has flagged a fresh FMA result. Without it, LOADB issues
// like any other memory op and fma_result_valid_in is ignored.
//
// Ports
//   clk_in               clock
//   rst_in               synchronous, active-high reset
//   start_in             start at PC 0 (ignored while busy)
//   imem_addr_out        program BRAM address (current PC)
//   imem_data_in         program BRAM read data, valid 2 cycles after address
//   fma_result_valid_in  pulse: FMA write buffer holds a new result
//   instr_out            instruction forwarded to the memory block
//   instr_valid_out      one-cycle qualifier for instr_out
//   reg_a/b/c_out        register values selected by the issued instruction
//   busy_out             high in FETCH0, FETCH1, EXEC and STALL
//   done_out             high after END until the next start
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, waiting for start_in
// FETCH0 | PC on imem_addr_out, BRAM read in flight
// FETCH1 | BRAM read in flight
// EXEC   | imem_data_in valid: decode, execute or issue
// STALL  | idle cycles after a WRITEB issue (down-counter to zero)
// DONE   | END executed, waiting for start_in

module fma_program_sequencer #(
    parameter int PROGRAM_DEPTH     = 256,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int WORD_WIDTH        = 16,
    parameter int WRITEB_STALL      = 3,
    localparam int PC_W             = $clog2(PROGRAM_DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    output logic [PC_W-1:0]              imem_addr_out,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
    input  logic                         fma_result_valid_in,
    output logic [INSTRUCTION_WIDTH-1:0] instr_out,
    output logic                         instr_valid_out,
    output logic [WORD_WIDTH-1:0]        reg_a_out,
    output logic [WORD_WIDTH-1:0]        reg_b_out,
    output logic [WORD_WIDTH-1:0]        reg_c_out,
    output logic                         busy_out,
    output logic                         done_out
);

    localparam int STALL_W = (WRITEB_STALL > 1) ? $clog2(WRITEB_STALL) : 1;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_END    = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd2;
    localparam logic [3:0] OP_ADDI   = 4'd3;
    localparam logic [3:0] OP_BGE    = 4'd4;
    localparam logic [3:0] OP_JUMP   = 4'd5;
    localparam logic [3:0] OP_SMA    = 4'd6;
    localparam logic [3:0] OP_LOADI  = 4'd7;
    localparam logic [3:0] OP_SENDL  = 4'd8;
    localparam logic [3:0] OP_LOADB  = 4'd9;
    localparam logic [3:0] OP_WRITEB = 4'd10;
    localparam logic [3:0] OP_LOAD   = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_EXEC,
        S_STALL,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [PC_W-1:0]                pc_q, pc_d;
    logic [WORD_WIDTH-1:0]          regs_q [16];
    logic [WORD_WIDTH-1:0]          regs_d [16];
    logic                           cmp_q, cmp_d;
    logic [STALL_W-1:0]             stall_cnt_q, stall_cnt_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic                           instr_valid_q, instr_valid_d;
    logic [WORD_WIDTH-1:0]          reg_a_q, reg_a_d;
    logic [WORD_WIDTH-1:0]          reg_b_q, reg_b_d;
    logic [WORD_WIDTH-1:0]          reg_c_q, reg_c_d;

    logic [3:0]                     op;
    logic [3:0]                     fld_a;
    logic [3:0]                     fld_b;
    logic [3:0]                     fld_c;
    logic [15:0]                    imm;
    logic [PC_W-1:0]                pc_inc;
    logic                           loadb_ok;

    assign op    = imem_data_in[31:28];
    assign fld_a = imem_data_in[27:24];
    assign imm   = imem_data_in[23:8];
    assign fld_b = imem_data_in[7:4];
    assign fld_c = imem_data_in[3:0];

    // Explicit wrap so non-power-of-two depths also return to 0.
    assign pc_inc = (pc_q == PC_W'(PROGRAM_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);

`ifdef FMA_SEQ_LOADB_HANDSHAKE_EN
    logic result_pending_q, result_pending_d;
    assign loadb_ok = result_pending_q;
`else
    logic unused_fma_result_valid;
    assign unused_fma_result_valid = fma_result_valid_in;
    assign loadb_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        regs_d        = regs_q;
        cmp_d         = cmp_q;
        stall_cnt_d   = stall_cnt_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        reg_a_d       = reg_a_q;
        reg_b_d       = reg_b_q;
        reg_c_d       = reg_c_q;
`ifdef FMA_SEQ_LOADB_HANDSHAKE_EN
        result_pending_d = result_pending_q | fma_result_valid_in;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    state_d = S_FETCH0;
                    pc_d    = '0;
                    regs_d  = '{default: '0};
                    cmp_d   = 1'b0;
                end
            end

            S_FETCH0: state_d = S_FETCH1;

            S_FETCH1: state_d = S_EXEC;

            S_EXEC: begin
                case (op)
                    OP_END: state_d = S_DONE;

                    OP_XOR: begin
                        regs_d[fld_a] = regs_q[fld_a] ^ regs_q[fld_b];
                        pc_d          = pc_inc;
                        state_d       = S_FETCH0;
                    end

                    OP_ADDI: begin
                        regs_d[fld_a] = regs_q[fld_b] + WORD_WIDTH'(imm);
                        pc_d          = pc_inc;
                        state_d       = S_FETCH0;
                    end

                    OP_BGE: begin
                        cmp_d   = (regs_q[fld_a] >= regs_q[fld_b]);
                        pc_d    = pc_inc;
                        state_d = S_FETCH0;
                    end

                    OP_JUMP: begin
                        pc_d    = cmp_q ? imm[PC_W-1:0] : pc_inc;
                        state_d = S_FETCH0;
                    end

                    OP_SMA, OP_LOADI, OP_SENDL, OP_LOADB, OP_WRITEB, OP_LOAD: begin
                        // A LOADB without a fresh result stays in EXEC; the
                        // BRAM output is stable because PC has not moved.
                        if (op != OP_LOADB || loadb_ok) begin
                            instr_d       = imem_data_in;
                            instr_valid_d = 1'b1;
                            reg_a_d       = regs_q[fld_a];
                            reg_b_d       = regs_q[fld_b];
                            reg_c_d       = regs_q[fld_c];
                            pc_d          = pc_inc;
                            state_d       = S_FETCH0;
`ifdef FMA_SEQ_LOADB_HANDSHAKE_EN
                            // A new result arriving in the issue cycle survives.
                            if (op == OP_LOADB) begin
                                result_pending_d = fma_result_valid_in;
                            end
`endif
                            if (op == OP_WRITEB && WRITEB_STALL != 0) begin
                                state_d     = S_STALL;
                                stall_cnt_d = STALL_W'(WRITEB_STALL - 1);
                            end
                        end
                    end

                    default: begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH0;
                    end
                endcase
            end

            S_STALL: begin
                if (stall_cnt_q == '0) begin
                    state_d = S_FETCH0;
                end else begin
                    stall_cnt_d = stall_cnt_q - STALL_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            regs_q        <= '{default: '0};
            cmp_q         <= 1'b0;
            stall_cnt_q   <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            reg_a_q       <= '0;
            reg_b_q       <= '0;
            reg_c_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            regs_q        <= regs_d;
            cmp_q         <= cmp_d;
            stall_cnt_q   <= stall_cnt_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            reg_a_q       <= reg_a_d;
            reg_b_q       <= reg_b_d;
            reg_c_q       <= reg_c_d;
        end
    end

`ifdef FMA_SEQ_LOADB_HANDSHAKE_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            result_pending_q <= 1'b0;
        end else begin
            result_pending_q <= result_pending_d;
        end
    end
`endif

    assign imem_addr_out   = pc_q;
    assign instr_out       = instr_q;
    assign instr_valid_out = instr_valid_q;
    assign reg_a_out       = reg_a_q;
    assign reg_b_out       = reg_b_q;
    assign reg_c_out       = reg_c_q;
    assign busy_out        = (state_q == S_FETCH0) || (state_q == S_FETCH1) ||
                             (state_q == S_EXEC)   || (state_q == S_STALL);
    assign done_out        = (state_q == S_DONE);

endmodule

// File: tb/tb_fma_program_sequencer.sv
module tb_fma_program_sequencer;

    localparam int DEPTH = 256;
    localparam int STALL = 3;
    localparam int MAXC  = 1024;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [7:0]  imem_addr_out;
    logic [31:0] imem_data_in;
    logic        fma_result_valid_in;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic [15:0] reg_a_out, reg_b_out, reg_c_out;
    logic        busy_out, done_out;

    always #5 clk = ~clk;

    fma_program_sequencer #(
        .PROGRAM_DEPTH(DEPTH),
        .INSTRUCTION_WIDTH(32),
        .WORD_WIDTH(16),
        .WRITEB_STALL(STALL)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .start_in(start_in),
        .imem_addr_out(imem_addr_out),
        .imem_data_in(imem_data_in),
        .fma_result_valid_in(fma_result_valid_in),
        .instr_out(instr_out),
        .instr_valid_out(instr_valid_out),
        .reg_a_out(reg_a_out),
        .reg_b_out(reg_b_out),
        .reg_c_out(reg_c_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    // Program memory with two-cycle read latency.
    logic [31:0] prog [DEPTH];
    logic [31:0] rd_stage;
    always @(posedge clk) begin
        rd_stage     <= prog[imem_addr_out];
        imem_data_in <= rd_stage;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Expected per-cycle behaviour, cycle 0 = first FETCH0 after start.
    logic        exp_valid [MAXC];
    logic [31:0] exp_instr [MAXC];
    logic [15:0] exp_ra [MAXC];
    logic [15:0] exp_rb [MAXC];
    logic [15:0] exp_rc [MAXC];
    logic        exp_fetch [MAXC];
    int          exp_pc [MAXC];
    int          done_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int a, input int imm, input int b, input int c);
        return {4'(op), 4'(a), 16'(imm), 4'(b), 4'(c)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'h0;
    endtask

    // Instruction-level interpreter: each instruction takes 3 cycles from
    // its fetch, WRITEB adds STALL more, memory ops appear 3 cycles after fetch.
    task automatic build_expect();
        logic [15:0] r [16];
        logic [31:0] ins;
        int          op, a, b, c, imm, pc, npc, t, gap, steps;
        bit          cmp;
        for (int i = 0; i < MAXC; i++) begin
            exp_valid[i] = 1'b0;
            exp_fetch[i] = 1'b0;
            exp_instr[i] = '0;
            exp_ra[i] = '0; exp_rb[i] = '0; exp_rc[i] = '0;
            exp_pc[i] = 0;
        end
        for (int i = 0; i < 16; i++) r[i] = '0;
        cmp = 0; pc = 0; t = 0; steps = 0; done_c = -1;
        while (done_c < 0 && steps < 300 && t < MAXC - 8) begin
            ins = prog[pc];
            op  = int'(ins[31:28]);
            a   = int'(ins[27:24]);
            imm = int'(ins[23:8]);
            b   = int'(ins[7:4]);
            c   = int'(ins[3:0]);
            exp_fetch[t] = 1'b1;
            exp_pc[t]    = pc;
            npc = (pc + 1) % DEPTH;
            gap = 3;
            case (op)
                1:  done_c = t + 3;
                2:  r[a] = r[a] ^ r[b];
                3:  r[a] = 16'(r[b] + imm);
                4:  cmp = (r[a] >= r[b]);
                5:  if (cmp) npc = imm % DEPTH;
                6, 7, 8, 9, 10, 13: begin
                    exp_valid[t+3] = 1'b1;
                    exp_instr[t+3] = ins;
                    exp_ra[t+3] = r[a];
                    exp_rb[t+3] = r[b];
                    exp_rc[t+3] = r[c];
                    if (op == 10) gap = gap + STALL;
                end
                default: ;
            endcase
            pc = npc;
            t = t + gap;
            steps++;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic run_program(input string name);
        int lim;
        build_expect();
        lim = (done_c < 0) ? MAXC - 4 : done_c + 1;
        do_start();
        for (int c = 0; c <= lim; c++) begin
            if (c > 0) @(negedge clk);
            if (exp_fetch[c])
                chk($sformatf("%s/addr@%0d", name, c), 32'(imem_addr_out), 32'(exp_pc[c]));
            chk($sformatf("%s/valid@%0d", name, c), 32'(instr_valid_out), 32'(exp_valid[c]));
            if (exp_valid[c]) begin
                chk($sformatf("%s/instr@%0d", name, c), instr_out, exp_instr[c]);
                chk($sformatf("%s/reg_a@%0d", name, c), 32'(reg_a_out), 32'(exp_ra[c]));
                chk($sformatf("%s/reg_b@%0d", name, c), 32'(reg_b_out), 32'(exp_rb[c]));
                chk($sformatf("%s/reg_c@%0d", name, c), 32'(reg_c_out), 32'(exp_rc[c]));
            end
            chk($sformatf("%s/busy@%0d", name, c), 32'(busy_out), 32'(c < done_c));
            chk($sformatf("%s/done@%0d", name, c), 32'(done_out), 32'(done_c >= 0 && c >= done_c));
            // A start pulse mid-run must be ignored.
            start_in = (c == 4 && done_c > 6);
        end
        start_in = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "/addr"},  32'(imem_addr_out), 32'h0);
        chk({name, "/instr"}, instr_out, 32'h0);
        chk({name, "/valid"}, 32'(instr_valid_out), 32'h0);
        chk({name, "/reg_a"}, 32'(reg_a_out), 32'h0);
        chk({name, "/reg_b"}, 32'(reg_b_out), 32'h0);
        chk({name, "/reg_c"}, 32'(reg_c_out), 32'h0);
        chk({name, "/busy"},  32'(busy_out), 32'h0);
        chk({name, "/done"},  32'(done_out), 32'h0);
    endtask

    task automatic gen_random();
        int op, tgt;
        logic [31:0] w;
        clear_prog();
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 15);
            if (op == 1) op = 3;
`ifdef FMA_SEQ_LOADB_HANDSHAKE_EN
            if (op == 9) op = 6;
`endif
            w = {4'(op), 4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom)};
            if (op == 5) begin
                tgt = $urandom_range(i + 1, 30);
                w[23:8] = {8'($urandom), 8'(tgt)};
            end
            prog[i] = w;
        end
        for (int j = 0; j < 6; j++)
            prog[24 + j] = mk(6, j * 3, $urandom_range(0, 65535), j * 3 + 1, j * 3 + 2);
        prog[30] = mk(1, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        start_in = 1'b0;
        fma_result_valid_in = 1'b0;
        clear_prog();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_in = 1'b0;

        // Two ADDIs then END: no pulses, done 9 cycles after first fetch.
        clear_prog();
        prog[0] = mk(3, 1, 5, 0, 0);
        prog[1] = mk(3, 2, 3, 1, 0);
        prog[2] = mk(1, 0, 0, 0, 0);
        run_program("addi_end");

        // Same, with r2 exposed through an SMA.
        prog[2] = mk(6, 2, 0, 1, 0);
        prog[3] = mk(1, 0, 0, 0, 0);
        run_program("addi_read");

        // Counted loop with a JUMP whose high immediate bits are discarded.
        clear_prog();
        prog[0] = mk(3, 2, 3, 0, 0);
        prog[1] = mk(3, 1, 1, 1, 0);
        prog[2] = mk(4, 2, 0, 1, 0);
        prog[3] = mk(5, 0, 16'hAB01, 0, 0);
        prog[4] = mk(6, 1, 0, 2, 0);
        prog[5] = mk(1, 0, 0, 0, 0);
        run_program("loop");

        // LOAD carrying r4 = 0x0400.
        clear_prog();
        prog[0] = mk(3, 4, 16'h0400, 0, 0);
        prog[1] = mk(13, 1, 2, 4, 0);
        prog[2] = mk(1, 0, 0, 0, 0);
        run_program("load");

        // WRITEB then SMA: stall spacing.
        clear_prog();
        prog[0] = mk(3, 3, 16'h00C3, 0, 0);
        prog[1] = mk(10, 3, 16'h1111, 0, 3);
        prog[2] = mk(6, 0, 16'h2222, 3, 0);
        prog[3] = mk(1, 0, 0, 0, 0);
        run_program("writeb");

        // PC wrap from 255 to 0, taken then untaken JUMP.
        clear_prog();
        prog[0]   = mk(4, 1, 0, 2, 0);
        prog[1]   = mk(5, 0, 16'h77FE, 0, 0);
        prog[2]   = mk(1, 0, 0, 0, 0);
        prog[254] = mk(3, 2, 1, 0, 0);
        prog[255] = mk(7, 2, 16'h0F0F, 1, 2);
        run_program("wrap");

        for (int k = 0; k < 8; k++) begin
            gen_random();
            run_program($sformatf("rand%0d", k));
        end

        // Reset during WRITEB stall.
        clear_prog();
        prog[0] = mk(3, 6, 16'h00AA, 0, 0);
        prog[1] = mk(10, 6, 0, 6, 6);
        prog[2] = mk(6, 0, 0, 0, 0);
        prog[3] = mk(1, 0, 0, 0, 0);
        do_start();
        repeat (7) @(negedge clk);
        chk("rst_stall/busy_before", 32'(busy_out), 32'h1);
        chk("rst_stall/reg_a_before", 32'(reg_a_out), 32'h00AA);
        rst_in = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_stall");
        rst_in = 1'b0;
        run_program("after_rst_stall");

        // Reset in the EXEC cycle of a memory op drops its pulse.
        clear_prog();
        prog[0] = mk(3, 5, 16'h1234, 0, 0);
        prog[1] = mk(6, 5, 0, 5, 5);
        prog[2] = mk(1, 0, 0, 0, 0);
        do_start();
        repeat (5) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_exec");
        rst_in = 1'b0;
        run_program("after_rst_exec");

`ifdef FMA_SEQ_LOADB_HANDSHAKE_EN
        // LOADB held until a result arrives; pulse at cycle 6 -> issue at 8.
        clear_prog();
        prog[0] = mk(9, 1, 16'h00AA, 2, 3);
        prog[1] = mk(1, 0, 0, 0, 0);
        do_start();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            fma_result_valid_in = (c == 6);
            if (c >= 3 && c <= 7) begin
                chk($sformatf("gate/held_valid@%0d", c), 32'(instr_valid_out), 32'h0);
                chk($sformatf("gate/held_busy@%0d", c), 32'(busy_out), 32'h1);
            end
            if (c == 8) begin
                chk("gate/issue_valid", 32'(instr_valid_out), 32'h1);
                chk("gate/issue_instr", instr_out, prog[0]);
            end
        end
        @(negedge clk);
        chk("gate/one_cycle", 32'(instr_valid_out), 32'h0);
        for (int k = 0; k < 20 && !done_out; k++) @(negedge clk);
        chk("gate/done", 32'(done_out), 32'h1);

        // Result arriving in the same cycle as a LOADB issue stays pending.
        fma_result_valid_in = 1'b1;
        @(negedge clk);
        fma_result_valid_in = 1'b0;
        clear_prog();
        prog[0] = mk(9, 1, 1, 2, 3);
        prog[1] = mk(9, 4, 2, 5, 6);
        prog[2] = mk(1, 0, 0, 0, 0);
        do_start();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            fma_result_valid_in = (c == 2);
            if (c == 3) chk("gate2/first", 32'(instr_valid_out), 32'h1);
            if (c == 5) chk("gate2/gap", 32'(instr_valid_out), 32'h0);
            if (c == 6) begin
                chk("gate2/second", 32'(instr_valid_out), 32'h1);
                chk("gate2/second_instr", instr_out, prog[1]);
            end
            if (c == 9) chk("gate2/done", 32'(done_out), 32'h1);
        end
        fma_result_valid_in = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
